// File: rtl/sel_arbiter_pkg.sv
// rtl/sel_arbiter_pkg.sv - types, constants and tie-break helper for sel_arbiter
// Purpose: typed wrappers around the shared encodings in sel_arbiter_defs.vh.
// Ports: none (package).
package sel_arbiter_pkg;

`include "sel_arbiter_defs.vh"

    typedef enum logic [1:0] {
        IDLE  = `SEL_ARB_ST_IDLE,
        GNT_A = `SEL_ARB_ST_GNT_A,
        GNT_B = `SEL_ARB_ST_GNT_B
    } state_t;

    // Which requester was granted most recently; the other one wins a tie.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    localparam int MAX_BURST_DEFAULT = `SEL_ARB_MAX_BURST_DEFAULT;

    // Wide enough for a terminal count of 15 (MAX_BURST up to 16).
    localparam int CNT_W = 4;

    function automatic state_t tie_winner(input last_t last);
        return (last == LAST_A) ? GNT_B : GNT_A;
    endfunction

endpackage

// File: rtl/sel_arbiter_if.sv
// rtl/sel_arbiter_if.sv - request/grant/data bundle between requesters and sel_arbiter
// Purpose: groups the two requesters' handshake and data lines with the shared output.
// Signals: req_a/req_b requests, a/b data, grant_a/grant_b grants, sel_o shared data,
//          busy = any grant.
// Modports: master (requester side, drives req/data), slave (arbiter side).
interface sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic a;
    logic b;
    logic grant_a;
    logic grant_b;
    logic sel_o;
    logic busy;

    modport master (
        output req_a, req_b, a, b,
        input  grant_a, grant_b, sel_o, busy
    );

    modport slave (
        input  req_a, req_b, a, b,
        output grant_a, grant_b, sel_o, busy
    );
endinterface

// File: rtl/sel_arbiter_burst_cnt.sv
// rtl/sel_arbiter_burst_cnt.sv - burst length counter with terminal-count flag
// Purpose: counts consecutive grant cycles and wraps to 0 after reaching limit.
// Ports: clk, reset (sync active-high), clear (restart at 0), en (count this cycle),
//        limit (terminal count), at_limit (counter equals limit).
module burst_cnt
    import sel_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            // Wrapping at the limit lets an uncontested holder keep its grant
            // while starting a fresh burst window.
            r_cnt <= at_limit ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign at_limit = (r_cnt == limit);

endmodule

// File: rtl/sel_arbiter_defs.vh
// rtl/sel_arbiter_defs.vh - shared state encodings and burst default for sel_arbiter
`ifndef SEL_ARBITER_DEFS_VH
`define SEL_ARBITER_DEFS_VH

`define SEL_ARB_ST_IDLE           2'd0
`define SEL_ARB_ST_GNT_A          2'd1
`define SEL_ARB_ST_GNT_B          2'd2
`define SEL_ARB_MAX_BURST_DEFAULT 4

`endif

// File: rtl/sel_arbiter.sv
// rtl/sel_arbiter.sv - two-requester arbiter with burst-limited rotation and registered mux
// Purpose: grants one of two requesters, alternating on ties and forcing rotation after
//          MAX_BURST consecutive grant cycles when the other side is waiting.
// Parameters: MAX_BURST (1..16) maximum consecutive grant cycles before forced rotation.
// Ports: clk, reset (sync active-high), bus (sel_arbiter_if.slave: req_a, req_b, a, b in;
//        grant_a, grant_b, sel_o, busy out, all driven from registers).
module sel_arbiter
    import sel_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
)(
    input  logic         clk,
    input  logic         reset,
    sel_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

    state_t r_state;
    state_t w_next;
    last_t  r_last;
    logic   r_sel;
    logic   w_at_limit;
    logic   w_clear;
    logic   w_en;

    burst_cnt u_burst_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .en       (w_en),
        .limit    (LIMIT),
        .at_limit (w_at_limit)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    w_next = tie_winner(r_last);
                end else if (bus.req_a) begin
                    w_next = GNT_A;
                end else if (bus.req_b) begin
                    w_next = GNT_B;
                end
            end
            GNT_A: begin
                // A drop and a burst expiry land in the same place, so the drop
                // check alone covers the case where both happen together.
                if (!bus.req_a) begin
                    w_next = bus.req_b ? GNT_B : IDLE;
                end else if (w_at_limit && bus.req_b) begin
                    w_next = GNT_B;
                end
            end
            GNT_B: begin
                if (!bus.req_b) begin
                    w_next = bus.req_a ? GNT_A : IDLE;
                end else if (w_at_limit && bus.req_a) begin
                    w_next = GNT_A;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Any state change restarts the burst window; holding a grant advances it.
    always_comb begin
        w_clear = (w_next != r_state);
        w_en    = (r_state != IDLE) && (w_next == r_state);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= LAST_B;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == GNT_A && r_state != GNT_A) begin
                r_last <= LAST_A;
            end else if (w_next == GNT_B && r_state != GNT_B) begin
                r_last <= LAST_B;
            end
            // Data follows the grant held during this cycle; IDLE keeps the
            // last delivered value on the shared output.
            case (r_state)
                GNT_A:   r_sel <= bus.a;
                GNT_B:   r_sel <= bus.b;
                default: r_sel <= r_sel;
            endcase
        end
    end

    assign bus.grant_a = (r_state == GNT_A);
    assign bus.grant_b = (r_state == GNT_B);
    assign bus.busy    = (r_state == GNT_A) || (r_state == GNT_B);
    assign bus.sel_o   = r_sel;

endmodule

// File: tb/tb_sel_arbiter.sv
// tb/tb_sel_arbiter.sv - self-checking bench for sel_arbiter against a behavioural model
module tb_sel_arbiter;

    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    sel_arbiter_if u_if ();

    sel_arbiter #(.MAX_BURST(MB)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, expected finish");
        $fatal(1, "watchdog");
    end

    // Model: holder 0=none,1=A,2=B; streak = grant cycles in the current window.
    int   m_holder = 0;
    int   m_streak = 0;
    int   m_last   = 2;
    logic m_sel    = 1'b0;

    task automatic model_step(input logic rst, input logic ra, input logic rb,
                              input logic da, input logic db);
        int   nh;
        logic mine;
        logic other;
        int   other_id;
        if (rst) begin
            m_holder = 0;
            m_streak = 0;
            m_last   = 2;
            m_sel    = 1'b0;
            return;
        end
        if (m_holder == 1) m_sel = da;
        else if (m_holder == 2) m_sel = db;
        mine     = (m_holder == 1) ? ra : (m_holder == 2) ? rb : 1'b0;
        other    = (m_holder == 1) ? rb : ra;
        other_id = (m_holder == 1) ? 2 : 1;
        if (m_holder == 0) begin
            if (ra && rb) nh = (m_last == 1) ? 2 : 1;
            else if (ra)  nh = 1;
            else if (rb)  nh = 2;
            else          nh = 0;
        end else if (!mine) begin
            nh = other ? other_id : 0;
        end else if (m_streak >= MB && other) begin
            nh = other_id;
        end else begin
            nh = m_holder;
        end
        if (nh != m_holder) begin
            m_streak = (nh != 0) ? 1 : 0;
            if (nh != 0) m_last = nh;
        end else if (nh != 0) begin
            m_streak = (m_streak == MB) ? 1 : m_streak + 1;
        end
        m_holder = nh;
    endtask

    function automatic logic [3:0] model_vec();
        return {m_holder == 1, m_holder == 2, m_holder != 0, m_sel};
    endfunction

    // One clock: inputs set before the call are the ones sampled; returns 1ns after the edge.
    task automatic cycle();
        logic rst_s;
        logic ra_s;
        logic rb_s;
        logic da_s;
        logic db_s;
        rst_s = reset;
        ra_s  = u_if.req_a;
        rb_s  = u_if.req_b;
        da_s  = u_if.a;
        db_s  = u_if.b;
        @(posedge clk);
        model_step(rst_s, ra_s, rb_s, da_s, db_s);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        u_if.req_a = 1'b0;
        u_if.req_b = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        u_if.req_a = 1'b1;
        u_if.req_b = 1'b1;
        u_if.a = 1'b1;
        u_if.b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if ({u_if.grant_a, u_if.grant_b, u_if.busy, u_if.sel_o} !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_outputs cycle %0d: got ga/gb/busy/sel=%b expected 0000", i,
                         {u_if.grant_a, u_if.grant_b, u_if.busy, u_if.sel_o});
            end
        end
        reset = 1'b0;
        cycle();
        n_checks++;
        if ({u_if.grant_a, u_if.grant_b} !== 2'b10) begin
            n_errors++;
            $display("FAIL reset_first_tie: got ga/gb=%b expected 10", {u_if.grant_a, u_if.grant_b});
        end
    endtask

    task automatic test_single();
        do_reset();
        u_if.req_a = 1'b0;
        u_if.req_b = 1'b1;
        u_if.b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            u_if.b = ~u_if.b;
            u_if.a = 1'($urandom);
            cycle();
            n_checks++;
            if ({u_if.grant_a, u_if.grant_b} !== 2'b01) begin
                n_errors++;
                $display("FAIL single_hold cycle %0d: got ga/gb=%b expected 01", i,
                         {u_if.grant_a, u_if.grant_b});
            end
            if (i >= 1) begin
                n_checks++;
                if (u_if.sel_o !== u_if.b) begin
                    n_errors++;
                    $display("FAIL single_sel cycle %0d: got sel_o=%b expected %b", i, u_if.sel_o, u_if.b);
                end
            end
        end
    endtask

    task automatic test_rotation();
        logic exp_a;
        do_reset();
        u_if.req_a = 1'b1;
        u_if.req_b = 1'b1;
        for (int i = 0; i < 6 * MB; i++) begin
            u_if.a = 1'($urandom);
            u_if.b = 1'($urandom);
            cycle();
            exp_a = (((i / MB) % 2) == 0);
            n_checks++;
            if ({u_if.grant_a, u_if.grant_b} !== {exp_a, ~exp_a}) begin
                n_errors++;
                $display("FAIL rotation cycle %0d: got ga/gb=%b expected %b", i,
                         {u_if.grant_a, u_if.grant_b}, {exp_a, ~exp_a});
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        u_if.req_a = 1'b1;
        u_if.req_b = 1'b1;
        repeat (2) begin
            cycle();
            n_checks++;
            if (u_if.grant_a !== 1'b1) begin
                n_errors++;
                $display("FAIL drop_pre: got grant_a=%b expected 1", u_if.grant_a);
            end
        end
        u_if.req_a = 1'b0;
        cycle();
        u_if.req_a = 1'b1;
        // B's window must be a fresh MB cycles long, counted from its entry.
        for (int i = 0; i < MB; i++) begin
            if (i > 0) cycle();
            n_checks++;
            if ({u_if.grant_a, u_if.grant_b} !== 2'b01) begin
                n_errors++;
                $display("FAIL drop_b_window cycle %0d: got ga/gb=%b expected 01", i,
                         {u_if.grant_a, u_if.grant_b});
            end
        end
        cycle();
        n_checks++;
        if ({u_if.grant_a, u_if.grant_b} !== 2'b10) begin
            n_errors++;
            $display("FAIL drop_back_to_a: got ga/gb=%b expected 10", {u_if.grant_a, u_if.grant_b});
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        u_if.req_a = 1'b0;
        u_if.req_b = 1'b1;
        u_if.b = 1'b1;
        repeat (3) begin
            cycle();
            n_checks++;
            if (u_if.grant_b !== 1'b1) begin
                n_errors++;
                $display("FAIL midrst_burst: got grant_b=%b expected 1", u_if.grant_b);
            end
        end
        reset = 1'b1;
        u_if.req_a = 1'b1;
        cycle();
        n_checks++;
        if ({u_if.grant_a, u_if.grant_b, u_if.busy, u_if.sel_o} !== 4'b0000) begin
            n_errors++;
            $display("FAIL midrst_cleared: got ga/gb/busy/sel=%b expected 0000",
                     {u_if.grant_a, u_if.grant_b, u_if.busy, u_if.sel_o});
        end
        reset = 1'b0;
        cycle();
        n_checks++;
        if ({u_if.grant_a, u_if.grant_b} !== 2'b10) begin
            n_errors++;
            $display("FAIL midrst_tie: got ga/gb=%b expected 10", {u_if.grant_a, u_if.grant_b});
        end
    endtask

    task automatic test_idle_hold();
        do_reset();
        u_if.req_a = 1'b1;
        u_if.req_b = 1'b0;
        u_if.a = 1'b1;
        repeat (2) cycle();
        u_if.req_a = 1'b0;
        cycle();
        n_checks++;
        if ({u_if.grant_a, u_if.grant_b, u_if.busy, u_if.sel_o} !== 4'b0001) begin
            n_errors++;
            $display("FAIL idle_enter: got ga/gb/busy/sel=%b expected 0001",
                     {u_if.grant_a, u_if.grant_b, u_if.busy, u_if.sel_o});
        end
        for (int i = 0; i < 4; i++) begin
            u_if.a = i[0];
            u_if.b = 1'($urandom);
            cycle();
            n_checks++;
            if (u_if.sel_o !== 1'b1) begin
                n_errors++;
                $display("FAIL idle_sel_hold cycle %0d: got sel_o=%b expected 1", i, u_if.sel_o);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            u_if.req_a = ($urandom_range(0, 9) < 7);
            u_if.req_b = ($urandom_range(0, 9) < 6);
            u_if.a     = 1'($urandom);
            u_if.b     = 1'($urandom);
            cycle();
            n_checks++;
            if ({u_if.grant_a, u_if.grant_b, u_if.busy, u_if.sel_o} !== model_vec()) begin
                n_errors++;
                $display("FAIL random cycle %0d: got ga/gb/busy/sel=%b expected %b", i,
                         {u_if.grant_a, u_if.grant_b, u_if.busy, u_if.sel_o}, model_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        u_if.req_a = 1'b0;
        u_if.req_b = 1'b0;
        u_if.a = 1'b0;
        u_if.b = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_drop();
        test_reset_mid_burst();
        test_idle_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
